// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Data-memory handshake states
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } dm_state_t;

    // Register $0 is hardwired to zero, so it never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dm_wait_fsm.sv
// Data-memory request/ready sequencer with a watchdog on the wait phase.
module dm_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_acc,
    input  logic dm_ready,
    output logic freeze,
    output logic dm_req,
    output logic wd_err
);

    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    dm_state_t       state_q, state_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            wd_err_q, wd_err_d;

    // State, wait counter and sticky watchdog flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            wd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wd_err_q   <= wd_err_d;
        end
    end

    // Next-state and handshake outputs; timeout releases the pipeline as if ready
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wd_err_d   = wd_err_q;
        freeze     = 1'b0;
        dm_req     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_acc) begin
                    dm_req = 1'b1;
                    if (!dm_ready) begin
                        freeze     = 1'b1;
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WW'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                dm_req = 1'b1;
                if (dm_ready) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WW'(TIMEOUT)) begin
                    wd_err_d   = 1'b1;
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign wd_err = wd_err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory freeze,
// branch squash and load-use bubble insertion, plus a stall-cycle counter.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rsAddr,
    input  logic [4:0]       id_rtAddr,
    input  logic             id_useRt,
    input  logic             ex_MemtoReg,
    input  logic [4:0]       ex_wrAddr,
    input  logic             mem_MemtoReg,
    input  logic             mem_MemWrite,
    input  logic             mem_taken,
    input  logic             dm_ready,
    output logic             dm_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             wd_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             freeze;
    logic             fsm_req;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    dm_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_dm_wait_fsm (
        .clk      (clk),
        .rst      (rst),
        .mem_acc  (mem_MemtoReg | mem_MemWrite),
        .dm_ready (dm_ready),
        .freeze   (freeze),
        .dm_req   (fsm_req),
        .wd_err   (wd_err)
    );

    // Load in EX feeding a source register of the instruction in ID
    always_comb begin
        load_use = ex_MemtoReg && (ex_wrAddr != REG_ZERO) &&
                   ((ex_wrAddr == id_rsAddr) || (id_useRt && (ex_wrAddr == id_rtAddr)));
    end

    // Priority mux: reset > memory freeze > branch flush > load-use > normal
    always_comb begin
        dm_req      = fsm_req & ~rst;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (mem_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
